// File: rtl/supersonic_pkg.sv
// Shared definitions for the ultrasonic range-finder block.
// Holds the controller state encoding, the default timing constants
// (50 MHz clock), the reserved "no valid reading" distance code and a
// saturating increment used by the millimetre counter.
package supersonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    localparam int DEF_TRIG_CYCLES   = 500;        // 10 us trigger pulse
    localparam int DEF_CYC_PER_MM    = 291;        // echo cycles per mm
    localparam int DEF_ECHO_WAIT_MAX = 50_000;     // trigger end -> echo rise
    localparam int DEF_ECHO_MAX      = 1_900_000;  // longest echo accepted
    localparam int DEF_HOLDOFF       = 3_000_000;  // sensor recovery time

    localparam logic [31:0] DIST_ERR = 32'hFFFF_FFFF;  // timeout / out of range
    localparam logic [31:0] MM_SAT   = 32'hFFFF_FFFE;  // largest real reading

    // Increment that sticks at MM_SAT so a real reading never aliases DIST_ERR.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == MM_SAT) ? MM_SAT : v + 32'd1;
    endfunction

endpackage

// File: rtl/supersonic_sync_edge.sv
// sync_edge: two-flop synchronizer followed by rise/fall edge detection.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   async_i   - input from another clock domain (or a pin)
//   rise_o    - one-cycle pulse on a synchronized 0->1 transition
//   fall_o    - one-cycle pulse on a synchronized 1->0 transition
// Edges appear two cycles after the input changes.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/supersonic.sv
// supersonic: HC-SR04 style ultrasonic distance controller.
// A rising edge on trigger (while idle) fires a TRIG_CYCLES pulse on
// sensor_trig, then the echo pulse width is measured and converted to mm.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   trigger      - measurement request (rising edge, synchronized here)
//   triggerSuc   - one-cycle pulse in the cycle sensor_trig falls
//   valid        - one-cycle pulse when distance is updated
//   distance     - last reading in mm, 32'hFFFF_FFFF on timeout
//   sensor_trig  - trigger pin to the sensor
//   sensor_echo  - echo pin from the sensor (asynchronous)
module supersonic
    import supersonic_pkg::*;
#(
    parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
    parameter int CYC_PER_MM    = DEF_CYC_PER_MM,
    parameter int ECHO_WAIT_MAX = DEF_ECHO_WAIT_MAX,
    parameter int ECHO_MAX      = DEF_ECHO_MAX,
    parameter int HOLDOFF       = DEF_HOLDOFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    output logic        triggerSuc,
    output logic        valid,
    output logic [31:0] distance,
    output logic        sensor_trig,
    input  logic        sensor_echo
);

    logic trig_rise, unused_trig_fall;
    logic echo_rise, echo_fall;

    sync_edge u_trig_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(trigger),
        .rise_o (trig_rise),
        .fall_o (unused_trig_fall)
    );

    sync_edge u_echo_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(sensor_echo),
        .rise_o (echo_rise),
        .fall_o (echo_fall)
    );

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;    // phase timer, reused by every state
    logic [31:0] pre_q, pre_d;    // echo cycles within the current mm
    logic [31:0] mm_q,  mm_d;
    logic [31:0] dist_q, dist_d;
    logic        strig_q, strig_d;
    logic        suc_q, suc_d;
    logic        vld_q, vld_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            mm_q    <= '0;
            dist_q  <= '0;
            strig_q <= 1'b0;
            suc_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            mm_q    <= mm_d;
            dist_q  <= dist_d;
            strig_q <= strig_d;
            suc_q   <= suc_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        mm_d    = mm_q;
        dist_d  = dist_q;
        strig_d = 1'b0;
        suc_d   = 1'b0;
        vld_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (trig_rise) begin
                    strig_d = 1'b1;
                    state_d = ST_TRIG;
                end
            end

            // The IDLE exit already supplied the first high cycle.
            ST_TRIG: begin
                if (cnt_q == 32'(TRIG_CYCLES - 1)) begin
                    suc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_ECHO;
                end else begin
                    strig_d = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                end
            end

            ST_WAIT_ECHO: begin
                if (echo_rise) begin
                    cnt_d   = '0;
                    pre_d   = '0;
                    mm_d    = '0;
                    state_d = ST_MEASURE;
                end else if (cnt_q == 32'(ECHO_WAIT_MAX - 1)) begin
                    dist_d  = DIST_ERR;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // Every MEASURE cycle counts, including the one that sees the
            // fall: the rise-detect cycle was echo-high too but spent in
            // WAIT_ECHO, so this keeps the total equal to the echo width.
            ST_MEASURE: begin
                if (pre_q == 32'(CYC_PER_MM - 1)) begin
                    pre_d = '0;
                    mm_d  = sat_inc(mm_q);
                end else begin
                    pre_d = pre_q + 32'd1;
                end
                cnt_d = cnt_q + 32'd1;
                if (echo_fall) begin
                    dist_d  = mm_d;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (cnt_q == 32'(ECHO_MAX - 1)) begin
                    dist_d  = DIST_ERR;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end

            // Trigger edges arriving here, even on the exit cycle, are dropped.
            ST_HOLD: begin
                if (cnt_q == 32'(HOLDOFF - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sensor_trig = strig_q;
    assign triggerSuc  = suc_q;
    assign valid       = vld_q;
    assign distance    = dist_q;

endmodule
